// File: rtl/rv32im_csr_access_unit.sv
// Zicsr sequencer: privilege/read-only check, then read-modify-write against the CSR regfile.
// Latency 1-4 cycles from accept to response; a single request is in flight, req_ready_o only in IDLE.
module rv32im_csr_access_unit #(
    parameter int XLEN      = 32,
    parameter int CSR_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [2:0]           funct3_i,
    input  logic [CSR_WIDTH-1:0] csr_addr_i,
    input  logic [4:0]           rs1_idx_i,
    input  logic [XLEN-1:0]      rs1_val_i,
    input  logic [4:0]           rd_idx_i,
    input  logic [1:0]           priviledge_mode_i,
    output logic [CSR_WIDTH-1:0] csr_addr_o,
    output logic                 csr_read_en_o,
    output logic                 csr_write_en_o,
    output logic [XLEN-1:0]      csr_wdata_o,
    input  logic [XLEN-1:0]      csr_rdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [XLEN-1:0]      rsp_rdata_o,
    output logic                 rsp_illegal_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [1:0]             r_op;
    logic [CSR_WIDTH-1:0]   r_addr;
    logic [XLEN-1:0]        r_src;
    logic [XLEN-1:0]        r_old;
    logic [XLEN-1:0]        r_new;
    logic                   r_do_read;
    logic                   r_do_write;
    logic                   r_illegal;

    logic                   w_accept;
    logic                   w_is_rw;
    logic                   w_do_read;
    logic                   w_do_write;
    logic                   w_illegal;
    logic [XLEN-1:0]        w_src;
    logic [XLEN-1:0]        w_modified;

    assign w_accept   = (r_state == S_IDLE) && req_valid_i;
    assign w_src      = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_val_i;
    assign w_is_rw    = (funct3_i[1:0] == 2'b01);
    assign w_do_read  = !(w_is_rw && (rd_idx_i == 5'd0));
    assign w_do_write = w_is_rw || (rs1_idx_i != 5'd0);
    // CSR address bits [11:10]==11 mark read-only, [9:8] the lowest privilege allowed
    assign w_illegal  = (funct3_i[1:0] == 2'b00)
                     || (csr_addr_i[9:8] > priviledge_mode_i)
                     || (w_do_write && (csr_addr_i[11:10] == 2'b11));

    always_comb begin
        w_modified = r_src;
        case (r_op)
            2'b10:   w_modified = csr_rdata_i | r_src;
            2'b11:   w_modified = csr_rdata_i & ~r_src;
            default: w_modified = r_src;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (w_illegal)      w_next = S_RESP;
                    else if (w_do_read) w_next = S_READ;
                    else                w_next = S_WRITE;
                end
            end
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = r_do_write ? S_WRITE : S_RESP;
            S_WRITE:   w_next = S_RESP;
            S_RESP:    if (rsp_ready_i) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_addr     <= '0;
            r_src      <= '0;
            r_old      <= '0;
            r_new      <= '0;
            r_do_read  <= 1'b0;
            r_do_write <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= funct3_i[1:0];
                r_addr     <= csr_addr_i;
                r_src      <= w_src;
                r_do_read  <= w_do_read;
                r_do_write <= w_do_write;
                r_illegal  <= w_illegal;
                // Cleared so no-read and illegal responses return zero; RW without read writes src
                r_old      <= '0;
                r_new      <= w_src;
            end else if (r_state == S_CAPTURE) begin
                r_old <= csr_rdata_i;
                r_new <= w_modified;
            end
        end
    end

    assign req_ready_o    = (r_state == S_IDLE);
    assign csr_addr_o     = r_addr;
    assign csr_read_en_o  = (r_state == S_READ);
    assign csr_write_en_o = (r_state == S_WRITE);
    assign csr_wdata_o    = r_new;
    assign rsp_valid_o    = (r_state == S_RESP);
    assign rsp_rdata_o    = r_old;
    assign rsp_illegal_o  = (r_state == S_RESP) && r_illegal;

endmodule

// File: tb/tb_rv32im_csr_access_unit.sv
// Bench for rv32im_csr_access_unit: directed vector table against a small CSR regfile model,
// plus hand sequences for response backpressure and reset during a read.
module tb_rv32im_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = '0;
    logic [11:0] addr_in = '0;
    logic [4:0]  rs1_idx = '0;
    logic [31:0] rs1_val = '0;
    logic [4:0]  rd_idx = '0;
    logic [1:0]  priv = '0;
    logic [11:0] csr_addr;
    logic        read_en;
    logic        write_en;
    logic [31:0] wdata;
    logic [31:0] rdata_rf = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32im_csr_access_unit #(.XLEN(32), .CSR_WIDTH(12)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .funct3_i(funct3), .csr_addr_i(addr_in), .rs1_idx_i(rs1_idx), .rs1_val_i(rs1_val),
        .rd_idx_i(rd_idx), .priviledge_mode_i(priv),
        .csr_addr_o(csr_addr), .csr_read_en_o(read_en), .csr_write_en_o(write_en),
        .csr_wdata_o(wdata), .csr_rdata_i(rdata_rf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_illegal_o(rsp_illegal)
    );

    // CSR regfile model: read data appears the cycle after the read strobe
    logic [31:0] mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_dat = '0;
    always @(posedge clk) begin
        if (pre_we)        mem[pre_addr] <= pre_dat;
        else if (write_en) mem[csr_addr] <= wdata;
        if (read_en)       rdata_rf <= mem[csr_addr];
    end

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1;
        logic [31:0] val;
        logic [4:0]  rd;
        logic [1:0]  priv;
        logic [31:0] init;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] f, input logic [11:0] a, input logic [4:0] r1,
                             input logic [31:0] v, input logic [4:0] rd, input logic [1:0] p);
        funct3 = f; addr_in = a; rs1_idx = r1; rs1_val = v; rd_idx = rd; priv = p;
        req_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t t);
        int lat, rd_cnt, wr_cnt, both;
        logic [31:0] wd, rdat;
        logic ill;
        lat = 0; rd_cnt = 0; wr_cnt = 0; both = 0; wd = '0; rdat = '0; ill = 1'b0;
        preload(t.addr, t.init);
        rsp_ready = 1'b1;
        drive_req(t.f3, t.addr, t.rs1, t.val, t.rd, t.priv);
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (read_en) rd_cnt++;
            if (write_en) begin wr_cnt++; wd = wdata; end
            if (read_en && write_en) both++;
            if (rsp_valid) begin
                lat = c; rdat = rsp_rdata; ill = rsp_illegal;
                break;
            end
        end
        check({t.name, " latency"}, lat, t.exp_lat);
        check({t.name, " rdata"}, rdat, t.exp_rdata);
        check({t.name, " illegal"}, {31'b0, ill}, {31'b0, t.exp_ill});
        check({t.name, " read strobes"}, rd_cnt, {31'b0, t.exp_rd});
        check({t.name, " write strobes"}, wr_cnt, {31'b0, t.exp_wr});
        check({t.name, " strobe overlap"}, both, 0);
        if (t.exp_wr) check({t.name, " wdata"}, wd, t.exp_wdata);
        @(negedge clk);
        check({t.name, " back to idle"}, {30'b0, req_ready, rsp_valid}, 32'd2);
        check({t.name, " csr value"}, mem[t.addr], t.exp_wr ? t.exp_wdata : t.init);
    endtask

    initial begin
        logic [31:0] h_rdata;
        int strobes, wr_seen;

        //            name       f3      addr     rs1    val            rd     pr     init           rd wr wdata          rdata          ill lat
        vecs[0]  = '{"csrrs",    3'b010, 12'h300, 5'd6,  32'h0000_0008, 5'd5,  2'b11, 32'h0000_1800, 1, 1, 32'h0000_1808, 32'h0000_1800, 0, 4};
        vecs[1]  = '{"csrrw_rd0",3'b001, 12'h300, 5'd7,  32'hF000_0000, 5'd0,  2'b11, 32'h0000_1808, 0, 1, 32'hF000_0000, 32'h0,         0, 2};
        vecs[2]  = '{"csrrci_z0",3'b111, 12'hB00, 5'd0,  32'hFFFF_FFFF, 5'd2,  2'b11, 32'h0000_0012, 1, 0, 32'h0,         32'h0000_0012, 0, 3};
        vecs[3]  = '{"rw_ro",    3'b001, 12'hF11, 5'd3,  32'h1234_5678, 5'd1,  2'b11, 32'h0000_0ABC, 0, 0, 32'h0,         32'h0,         1, 1};
        vecs[4]  = '{"rs_priv",  3'b010, 12'h300, 5'd1,  32'h0000_0001, 5'd1,  2'b00, 32'h0000_1800, 0, 0, 32'h0,         32'h0,         1, 1};
        vecs[5]  = '{"f3_100",   3'b100, 12'h300, 5'd1,  32'h0000_0001, 5'd1,  2'b11, 32'h0000_1800, 0, 0, 32'h0,         32'h0,         1, 1};
        vecs[6]  = '{"csrrc",    3'b011, 12'h300, 5'd2,  32'h0000_00F0, 5'd3,  2'b11, 32'h0000_FFFF, 1, 1, 32'h0000_FF0F, 32'h0000_FFFF, 0, 4};
        vecs[7]  = '{"csrrsi",   3'b110, 12'h340, 5'd5,  32'hFFFF_0000, 5'd3,  2'b11, 32'h0000_0010, 1, 1, 32'h0000_0015, 32'h0000_0010, 0, 4};
        vecs[8]  = '{"csrrwi",   3'b101, 12'h340, 5'd31, 32'hFFFF_0000, 5'd4,  2'b11, 32'h0000_00AA, 1, 1, 32'h0000_001F, 32'h0000_00AA, 0, 4};
        vecs[9]  = '{"rs_ro_rd", 3'b010, 12'hF11, 5'd0,  32'hFFFF_FFFF, 5'd6,  2'b11, 32'h0000_CAFE, 1, 0, 32'h0,         32'h0000_CAFE, 0, 3};
        vecs[10] = '{"s_csr_rd", 3'b010, 12'h100, 5'd0,  32'h0,         5'd6,  2'b01, 32'h0000_0055, 1, 0, 32'h0,         32'h0000_0055, 0, 3};
        vecs[11] = '{"rw_s_m",   3'b001, 12'h300, 5'd9,  32'h0000_0001, 5'd1,  2'b01, 32'h0000_1800, 0, 0, 32'h0,         32'h0,         1, 1};

        #12;
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset strobes/valid/illegal", {28'b0, read_en, write_en, rsp_valid, rsp_illegal}, 32'd0);
        check("reset csr_addr", {20'b0, csr_addr}, 32'd0);
        check("reset wdata", wdata, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure: response held for 5 cycles while another request waits
        preload(12'h340, 32'h0000_0077);
        rsp_ready = 1'b0;
        drive_req(3'b010, 12'h340, 5'd0, 32'h0, 5'd1, 2'b11);
        @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) break;
        end
        check("hold rsp_valid reached", {31'b0, rsp_valid}, 32'd1);
        h_rdata = rsp_rdata;
        check("hold first rdata", h_rdata, 32'h0000_0077);
        strobes = 0;
        drive_req(3'b001, 12'h340, 5'd1, 32'h0000_DEAD, 5'd0, 2'b11);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (read_en || write_en) strobes++;
            check("hold rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold rdata", rsp_rdata, 32'h0000_0077);
            check("hold illegal", {31'b0, rsp_illegal}, 32'd0);
            check("hold req_ready", {31'b0, req_ready}, 32'd0);
            check("hold csr_addr", {20'b0, csr_addr}, 32'h340);
        end
        check("hold no strobes", strobes, 0);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("hold release idle", {30'b0, req_ready, rsp_valid}, 32'd2);
        check("hold request ignored", mem[12'h340], 32'h0000_0077);

        // Reset asserted while the read strobe is up
        preload(12'h300, 32'h0000_1800);
        drive_req(3'b010, 12'h300, 5'd6, 32'h0000_0008, 5'd5, 2'b11);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst read strobe up", {31'b0, read_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst strobes/valid/illegal", {28'b0, read_en, write_en, rsp_valid, rsp_illegal}, 32'd0);
        check("rst csr_addr", {20'b0, csr_addr}, 32'd0);
        check("rst wdata", wdata, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (write_en || read_en || rsp_valid) wr_seen++;
        end
        check("rst no later activity", wr_seen, 0);
        check("rst idle after", {31'b0, req_ready}, 32'd1);
        check("rst csr unchanged", mem[12'h300], 32'h0000_1800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv32im_csr_access_unit.md
# rv32im_csr_access_unit

Sequencer between the execute stage and `rv32im_csr_regfile`. It accepts one decoded Zicsr instruction (CSRRW/CSRRS/CSRRC and their immediate forms) and checks privilege and read-only access. It then runs the read-modify-write against the CSR register file over that block's `csr_addr`/`read_en`/`write_en`/data ports, and returns the old CSR value, or an illegal-instruction flag, to writeback through a valid/ready handshake.

## Interface
- `XLEN`, default 32, data width.
- `CSR_WIDTH`, default 12, CSR address width.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit can accept a request; high only in IDLE.
- `funct3_i`  in  3  Zicsr funct3.
- `csr_addr_i`  in  CSR_WIDTH  target CSR.
- `rs1_idx_i`  in  5  rs1 index; also the zimm value for the immediate forms.
- `rs1_val_i`  in  XLEN  rs1 register value.
- `rd_idx_i`  in  5  destination index.
- `priviledge_mode_i`  in  2  current mode (regfile `priviledge_mode_o`).
- `csr_addr_o`  out  CSR_WIDTH  address to regfile.
- `csr_read_en_o`  out  1  regfile read strobe.
- `csr_write_en_o`  out  1  regfile write strobe.
- `csr_wdata_o`  out  XLEN  value to regfile `val_csr_i`.
- `csr_rdata_i`  in  XLEN  regfile `val_csr_o`; valid the cycle after `csr_read_en_o`.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  writeback accepts response.
- `rsp_rdata_o`  out  XLEN  old CSR value, zero-extended to XLEN.
- `rsp_illegal_o`  out  1  illegal-instruction exception.

## Operation
**Source operand**
- funct3[2]=1 selects zimm = `{27'b0, rs1_idx_i}`.
- funct3[2]=0 selects `rs1_val_i`.

**Function by funct3[1:0]**
- 01 RW: new = src.
- 10 RS: new = old | src.
- 11 RC: new = old & ~src.
- 00: illegal (funct3 000 and 100).

**Read and write enables**
- do_read = 0 only for RW/RWI with `rd_idx_i`==0; otherwise 1.
- do_write = 1 for RW/RWI.
- For RS/RC/RSI/RCI, do_write = (`rs1_idx_i` != 0).

**Illegal conditions** (evaluated at accept; any one sets illegal)
- funct3[1:0]==00.
- `csr_addr_i[9:8]` > `priviledge_mode_i`.
- do_write=1 and `csr_addr_i[11:10]`==2'b11.

**State machine** (one-hot or binary): IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE: on `req_valid_i`, latch all request fields, illegal, do_read and do_write. Next state is RESP if illegal, else READ if do_read, else WRITE.
- READ: `csr_read_en_o`=1 for exactly one cycle, then CAPTURE.
- CAPTURE: latch `csr_rdata_i` into old and compute new. Next state is WRITE if do_write, else RESP.
- WRITE: `csr_write_en_o`=1 for exactly one cycle with `csr_wdata_o`=new, then RESP. For RW forms with no read, new = src.
- RESP: `rsp_valid_o`=1. Hold all response outputs stable until `rsp_ready_i`=1, then IDLE.

**Response contents**
- `rsp_rdata_o` = old if do_read, else 0.
- If illegal: `rsp_rdata_o`=0 and `rsp_illegal_o`=1, and no read or write strobe is issued.

## Timing
**Reset**
- State IDLE.
- `req_ready_o`=1.
- `csr_read_en_o`, `csr_write_en_o`, `rsp_valid_o` and `rsp_illegal_o` = 0.
- `csr_addr_o`, `csr_wdata_o` and `rsp_rdata_o` = 0.

**Latency** (accept edge = T)
- RS/RC with write: READ at T+1, CAPTURE at T+2, WRITE at T+3, `rsp_valid_o` at T+4.
- Read-only (rs1=0): `rsp_valid_o` at T+3.
- RW with rd=0: WRITE at T+1, `rsp_valid_o` at T+2.
- Illegal: `rsp_valid_o` at T+1.

**Handshake and held signals**
- `csr_addr_o` is held at the latched address from T+1 until leaving RESP.
- Strobes are single-cycle and never assert together.
- A new request is accepted no earlier than the cycle after the RESP handshake. There is no back-to-back overlap.
- `rsp_ready_i` already high on entry to RESP: the response is valid for one cycle, and the unit is back in IDLE the next cycle.

**Boundary conditions**
- Reset mid-operation: return to IDLE immediately. Any pending write is dropped, and no strobe asserts after `rst_i` rises.
- Request inputs are ignored outside IDLE.

## Test plan
- Regfile model: mstatus (0x300) = 0x00001800, priv=11. CSRRS rd=5, rs1=6, rs1_val=0x00000008 → read at T+1, write 0x00001808 at T+3, rsp_rdata=0x00001800 at T+4, illegal=0.
- CSRRW rd=0, rs1_val=0xF0000000 to mstatus → no read strobe, write 0xF0000000 at T+1, rsp_rdata=0 at T+2.
- CSRRCI zimm=0 on mcycle (0xB00) holding 0x12 → read only, no write strobe, rsp_rdata=0x12 at T+3.
- Illegal cases, each giving rsp_illegal=1 at T+1 with no strobes:
  - CSRRW to 0xF11 (read-only).
  - CSRRS to 0x300 with priv=00.
  - funct3=100.
- Hold `rsp_ready_i`=0 for 5 cycles in RESP → outputs stable and `req_ready_o`=0; a request presented meanwhile is not accepted.
- Assert `rst_i` during READ → next edge IDLE, no write strobe, all outputs at reset values.
